output_reg_arbiter: RTL and testbench

// - Shares the single 256-bit output register among NUM_REQ requesters (e.g. ALU, matrix unit, host bus).
// - Arbitrates the requests and drives the register's write/read strobes as one-cycle pulses.
// - Captures read data and returns a one-hot ack per completed transaction.
// - Sits between the execution units and the output register; the only block allowed to drive its strobes.

---
 rtl/output_reg_arbiter_pkg.sv | 18 +
 rtl/output_reg_arbiter_if.sv | 30 +++
 rtl/output_reg_arbiter_rr.sv | 36 +++
 rtl/output_reg_arbiter.sv | 107 ++++++++++
 tb/tb_output_reg_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/output_reg_arbiter_pkg.sv
// outreg_pkg: state encoding, data width and index-width helper shared by the output register arbiter
package outreg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        ACK  = 3'd4
    } state_t;

    localparam int OUTREG_DATA_W = 256;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_reg_arbiter_if.sv
// output_reg_arbiter_if: requester-side handshake plus output-register strobe/data bus
interface output_reg_arbiter_if
    import outreg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = OUTREG_DATA_W
);

    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ-1:0]        req_rd;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rd_data;
    logic                      busy;
    logic                      reg_write_data;
    logic                      reg_read_data;
    logic [DATA_W-1:0]         reg_wdata;
    logic [DATA_W-1:0]         reg_rdata;

    modport master (
        output req_wr, req_rd, req_wdata, reg_rdata,
        input  ack, rd_data, busy, reg_write_data, reg_read_data, reg_wdata
    );

    modport slave (
        input  req_wr, req_rd, req_wdata, reg_rdata,
        output ack, rd_data, busy, reg_write_data, reg_read_data, reg_wdata
    );

endinterface

// File: rtl/output_reg_arbiter_rr.sv
// rr_arbiter: combinational requester pick, round-robin from base pointer or fixed priority under OUTREG_ARB_FIXED_PRIO_EN
module rr_arbiter
    import outreg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_w(NUM_REQ)
) (
`ifndef OUTREG_ARB_FIXED_PRIO_EN
    input  logic [IW-1:0]      rr_ptr_i,
`endif
    input  logic [NUM_REQ-1:0] req_i,
    output logic [IW-1:0]      gnt_o,
    output logic               valid_o
);

    logic [IW-1:0] base;
    logic [IW-1:0] idx;

`ifdef OUTREG_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    assign base = rr_ptr_i;
`endif

    // Scan from farthest to nearest offset so the requester closest to base wins
    always_comb begin
        gnt_o   = '0;
        valid_o = |req_i;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(base) + k) % NUM_REQ);
            if (req_i[idx]) gnt_o = idx;
        end
    end

endmodule

// File: rtl/output_reg_arbiter.sv
// output_reg_arbiter: shares the output register among requesters with one-cycle strobes and one-hot acks
// Define OUTREG_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module output_reg_arbiter
    import outreg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = OUTREG_DATA_W
) (
    input logic                 clk,
    input logic                 reset,
    output_reg_arbiter_if.slave bus
);

    localparam int IW = idx_w(NUM_REQ);

    state_t             state_q;
    logic [IW-1:0]      g_q;
    logic [IW-1:0]      gnt;
    logic               gnt_v;
    logic [NUM_REQ-1:0] ack_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               busy_q;
    logic               wr_q;
    logic               rd_q;

`ifdef OUTREG_ARB_FIXED_PRIO_EN
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req_i  (bus.req_wr | bus.req_rd),
        .gnt_o  (gnt),
        .valid_o(gnt_v)
    );
`else
    logic [IW-1:0] rr_ptr_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .rr_ptr_i(rr_ptr_q),
        .req_i   (bus.req_wr | bus.req_rd),
        .gnt_o   (gnt),
        .valid_o (gnt_v)
    );
`endif

    // Transaction FSM: grant in IDLE, pulse one strobe, capture read data, pulse ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            g_q       <= '0;
            ack_q     <= '0;
            rd_data_q <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
`ifndef OUTREG_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            ack_q <= '0;
            case (state_q)
                IDLE: if (gnt_v) begin
                    g_q     <= gnt;
                    wdata_q <= bus.req_wdata[gnt*DATA_W +: DATA_W];
                    busy_q  <= 1'b1;
                    if (bus.req_wr[gnt]) begin
                        state_q <= WR;
                        wr_q    <= 1'b1;
                    end else begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                    end
                end
                WR: begin
                    state_q <= ACK;
                    ack_q   <= NUM_REQ'(1) << g_q;
                end
                RD: state_q <= CAP;
                CAP: begin
                    rd_data_q <= bus.reg_rdata;
                    state_q   <= ACK;
                    ack_q     <= NUM_REQ'(1) << g_q;
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`ifndef OUTREG_ARB_FIXED_PRIO_EN
                    rr_ptr_q <= (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack            = ack_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.busy           = busy_q;
    assign bus.reg_write_data = wr_q;
    assign bus.reg_read_data  = rd_q;
    assign bus.reg_wdata      = wdata_q;

endmodule

// File: tb/tb_output_reg_arbiter.sv
// tb_output_reg_arbiter: directed checks of output_reg_arbiter against a simple output register model
module tb_output_reg_arbiter;
    import outreg_pkg::*;

    localparam int N = 4;
    localparam int W = 256;
    localparam logic [W-1:0] DA5   = {32{8'hA5}};
    localparam logic [W-1:0] D0123 = {8{32'h01234567}};
    localparam logic [W-1:0] DBEEF = {8{32'hDEADBEEF}};
    localparam logic [W-1:0] DCAFE = {8{32'hCAFEF00D}};

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] model = '0;
    int           checks   = 0;
    int           failures = 0;

    output_reg_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    output_reg_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Output register: loads on the write strobe edge
    always @(posedge clk) if (bus.reg_write_data) model <= bus.reg_wdata;
    assign bus.reg_rdata = model;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_wd(input int i, input logic [W-1:0] v);
        bus.req_wdata[i*W +: W] = v;
    endtask

    function automatic logic [W-1:0] rr_dat(input int i);
        logic [3:0] nib;
        nib = 4'(i + 1);
        return {64{nib}};
    endfunction

    initial begin
        int order[5];
        int n;
`ifdef OUTREG_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        bus.req_wr    = '0;
        bus.req_rd    = '0;
        bus.req_wdata = '0;
        repeat (2) cyc();
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wstb", bus.reg_write_data, 0);
        chk("rst_rstb", bus.reg_read_data, 0);
        chk("rst_rdata", bus.rd_data, 0);
        chk("rst_wdata", bus.reg_wdata, 0);
        reset = 1'b0;
        cyc();
        chk("idle_busy", bus.busy, 0);
        chk("idle_ack", bus.ack, 0);

        bus.req_wr[1] = 1'b1;
        set_wd(1, DA5);
        cyc();
        chk("w1_wstb", bus.reg_write_data, 1);
        chk("w1_rstb", bus.reg_read_data, 0);
        chk("w1_wdata", bus.reg_wdata, DA5);
        chk("w1_ack_early", bus.ack, 0);
        chk("w1_busy", bus.busy, 1);
        cyc();
        chk("w1_ack", bus.ack, 4'b0010);
        chk("w1_wstb_off", bus.reg_write_data, 0);
        bus.req_wr[1] = 1'b0;
        cyc();
        chk("w1_idle", bus.busy, 0);
        chk("w1_ack_off", bus.ack, 0);
        chk("w1_model", model, DA5);

        bus.req_wr[0] = 1'b1;
        set_wd(0, D0123);
        cyc();
        chk("w0_wstb", bus.reg_write_data, 1);
        cyc();
        chk("w0_ack", bus.ack, 4'b0001);
        bus.req_wr[0] = 1'b0;
        cyc();
        chk("w0_model", model, D0123);

        bus.req_rd[2] = 1'b1;
        cyc();
        chk("r2_rstb", bus.reg_read_data, 1);
        chk("r2_wstb", bus.reg_write_data, 0);
        cyc();
        chk("r2_cap_ack", bus.ack, 0);
        chk("r2_cap_rstb", bus.reg_read_data, 0);
        chk("r2_cap_busy", bus.busy, 1);
        cyc();
        chk("r2_ack", bus.ack, 4'b0100);
        chk("r2_rdata", bus.rd_data, D0123);
        bus.req_rd[2] = 1'b0;
        cyc();
        chk("r2_hold", bus.rd_data, D0123);
        chk("r2_idle", bus.busy, 0);

        bus.req_wr[3] = 1'b1;
        set_wd(3, DBEEF);
        cyc();
        set_wd(3, ~DBEEF);
        chk("dc_wdata", bus.reg_wdata, DBEEF);
        cyc();
        chk("dc_ack", bus.ack, 4'b1000);
        chk("dc_wdata_frozen", bus.reg_wdata, DBEEF);
        bus.req_wr[3] = 1'b0;
        cyc();
        chk("dc_model", model, DBEEF);

        for (int i = 0; i < N; i++) begin
            bus.req_wr[i] = 1'b1;
            set_wd(i, rr_dat(i));
        end
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.ack == '0 && n < 10) begin
                cyc();
                n++;
            end
            chk("rr_ack", bus.ack, N'(1) << order[k]);
            chk("rr_lat", n, 2);
            chk("rr_model", model, rr_dat(order[k]));
            if (k == 4) bus.req_wr = '0;
            cyc();
        end

        bus.req_wr[2] = 1'b1;
        bus.req_rd[2] = 1'b1;
        set_wd(2, DCAFE);
        cyc();
        chk("wr_first_wstb", bus.reg_write_data, 1);
        chk("wr_first_rstb", bus.reg_read_data, 0);
        cyc();
        chk("wr_first_ack", bus.ack, 4'b0100);
        bus.req_wr[2] = 1'b0;
        cyc();
        chk("rd_after_idle", bus.busy, 0);
        cyc();
        chk("rd_after_rstb", bus.reg_read_data, 1);
        cyc();
        cyc();
        chk("rd_after_ack", bus.ack, 4'b0100);
        chk("rd_after_data", bus.rd_data, DCAFE);
        bus.req_rd[2] = 1'b0;
        cyc();

        bus.req_rd[1] = 1'b1;
        cyc();
        chk("mid_rstb", bus.reg_read_data, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rstb_off", bus.reg_read_data, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_ack", bus.ack, 0);
        chk("mid_rdata", bus.rd_data, 0);
        chk("mid_wdata", bus.reg_wdata, 0);
        bus.req_rd[1] = 1'b0;
        cyc();
        chk("mid_ack_hold", bus.ack, 0);
        reset = 1'b0;
        cyc();
        cyc();
        chk("post_ack", bus.ack, 0);
        chk("post_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
